// File: rtl/arty_dma_calib_gate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : arty_dma_calib_gate                                              |
// | Brief   : Gates bsg_cache DMA packets until DDR calibration completes,     |
// |           allows one transaction at a time and flags stalls and stray      |
// |           read beats. Define ARTY_DMA_GATE_PERF_EN to build the counters.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module arty_dma_calib_gate #(
  parameter int dma_pkt_width_p       = 29,
  parameter int data_width_p          = 64,
  parameter int block_size_in_words_p = 8,
  parameter int timeout_cycles_p      = 4096
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       calib_done_i,
  input  logic [dma_pkt_width_p-1:0] core_pkt_i,
  input  logic                       core_pkt_v_i,
  output logic                       core_pkt_yumi_o,
  output logic [data_width_p-1:0]    core_data_o,
  output logic                       core_data_v_o,
  input  logic                       core_data_ready_and_i,
  input  logic [data_width_p-1:0]    core_data_i,
  input  logic                       core_data_v_i,
  output logic                       core_data_yumi_o,
  output logic [dma_pkt_width_p-1:0] mem_pkt_o,
  output logic                       mem_pkt_v_o,
  input  logic                       mem_pkt_yumi_i,
  input  logic [data_width_p-1:0]    mem_data_i,
  input  logic                       mem_data_v_i,
  output logic                       mem_data_ready_and_o,
  output logic [data_width_p-1:0]    mem_data_o,
  output logic                       mem_data_v_o,
  input  logic                       mem_data_yumi_i,
  output logic                       busy_o,
  output logic                       err_unexp_o,
  output logic                       err_timeout_o,
  output logic [31:0]                rd_count_o,
  output logic [31:0]                wr_count_o
);

  localparam int CNT_W = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
  localparam int WD_W  = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(block_size_in_words_p - 1);
  localparam logic [WD_W-1:0]  c_wd_max   = WD_W'(timeout_cycles_p - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_calib_meta;
  logic             r_calib_q;
  logic [CNT_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wd;
  logic             r_err_unexp;
  logic             r_err_timeout;
  logic             w_pkt_accept;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_in_xfer;

  // calib_done_i comes from the MIG ui_clk domain; it only gates new packets.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_calib_meta <= 1'b0;
      r_calib_q    <= 1'b0;
    end else begin
      r_calib_meta <= calib_done_i;
      r_calib_q    <= r_calib_meta;
    end
  end

  assign w_in_xfer    = (r_state == ST_READ) || (r_state == ST_WRITE);
  assign w_pkt_accept = mem_pkt_v_o & mem_pkt_yumi_i;
  assign w_beat       = ((r_state == ST_READ)  & mem_data_v_i & core_data_ready_and_i)
                      | ((r_state == ST_WRITE) & mem_data_yumi_i);
  assign w_last_beat  = w_beat & (r_cnt == c_cnt_last);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pkt_accept) begin
          w_state_next = core_pkt_i[dma_pkt_width_p-1] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        if (w_last_beat) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_pkt_o            = core_pkt_i;
    mem_pkt_v_o          = core_pkt_v_i & r_calib_q & (r_state == ST_IDLE);
    core_pkt_yumi_o      = mem_pkt_yumi_i & mem_pkt_v_o;
    core_data_o          = mem_data_i;
    mem_data_o           = core_data_i;
    core_data_v_o        = 1'b0;
    mem_data_ready_and_o = 1'b0;
    mem_data_v_o         = 1'b0;
    core_data_yumi_o     = 1'b0;
    case (r_state)
      ST_READ: begin
        core_data_v_o        = mem_data_v_i;
        mem_data_ready_and_o = core_data_ready_and_i;
      end
      ST_WRITE: begin
        mem_data_v_o     = core_data_v_i;
        core_data_yumi_o = mem_data_yumi_i;
      end
      default: begin
        core_data_v_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
    end else if (w_pkt_accept) begin
      r_cnt <= '0;
    end else if (w_beat) begin
      r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
    end
  end

  // Watchdog saturates at its limit; a late stream still completes the block.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wd <= '0;
    end else if (w_pkt_accept || w_beat) begin
      r_wd <= '0;
    end else if (w_in_xfer && (r_wd != c_wd_max)) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err_unexp   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_unexp   <= r_err_unexp | (mem_data_v_i & (r_state != ST_READ));
      r_err_timeout <= r_err_timeout | (w_in_xfer & (r_wd == c_wd_max));
    end
  end

  assign busy_o        = (r_state != ST_IDLE);
  assign err_unexp_o   = r_err_unexp;
  assign err_timeout_o = r_err_timeout;

`ifdef ARTY_DMA_GATE_PERF_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_last_beat) begin
      if (r_state == ST_READ) begin
        r_rd_count <= r_rd_count + 32'd1;
      end else begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign rd_count_o = r_rd_count;
  assign wr_count_o = r_wr_count;
`else
  assign rd_count_o = 32'd0;
  assign wr_count_o = 32'd0;
`endif

endmodule
`default_nettype wire
